// File: rtl/adc_train_pkg.sv
// Shared definitions for the ADC link-training controller.
//   - FSM state encoding (plain localparams so legacy tools can consume them)
//   - default training pattern and tap-counter width
package adc_train_pkg;

  // Width of the tap, window-length and target arithmetic.
  localparam int unsigned TapW = 8;

  // Aligned training word transmitted by the ADC in test-pattern mode.
  localparam logic [5:0] DefPattern = 6'b111000;

  // Bitslips attempted before declaring failure; six would wrap back to the start.
  localparam logic [2:0] MaxSlips = 3'd5;

  localparam logic [3:0] StIdle      = 4'd0;
  localparam logic [3:0] StDlyRst    = 4'd1;
  localparam logic [3:0] StSettle    = 4'd2;
  localparam logic [3:0] StCheck     = 4'd3;
  localparam logic [3:0] StStep      = 4'd4;
  localparam logic [3:0] StEval      = 4'd5;
  localparam logic [3:0] StCenterRst = 4'd6;
  localparam logic [3:0] StCenterInc = 4'd7;
  localparam logic [3:0] StSlipCheck = 4'd8;
  localparam logic [3:0] StSlip      = 4'd9;
  localparam logic [3:0] StLocked    = 4'd10;
  localparam logic [3:0] StFail      = 4'd11;

endpackage

// File: rtl/adc_eye_track.sv
// Eye-window tracker for the IODELAY sweep.
// Keeps the current run of good taps and the best (longest) run seen so far.
// A strictly longer run replaces the best one, so the first window wins ties.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        clear all window state (new training run)
//   valid_i        one tap result is presented this cycle
//   good_i         tap result: 1 = good, 0 = bad (closes the current run)
//   tap_i          tap the result belongs to
//   close_i        end of sweep: close any open run
//   best_start_o   first tap of the best window
//   best_len_o     length of the best window in taps
module adc_eye_track
  import adc_train_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            valid_i,
  input  logic            good_i,
  input  logic [TapW-1:0] tap_i,
  input  logic            close_i,
  output logic [TapW-1:0] best_start_o,
  output logic [TapW-1:0] best_len_o
);

  logic [TapW-1:0] cur_start_q, cur_start_d;
  logic [TapW-1:0] cur_len_q, cur_len_d;
  logic [TapW-1:0] best_start_q, best_start_d;
  logic [TapW-1:0] best_len_q, best_len_d;
  logic            close_run;

  always_comb begin
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    close_run    = close_i | (valid_i & ~good_i);

    if (clear_i) begin
      cur_start_d  = '0;
      cur_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (valid_i && good_i) begin
      if (cur_len_q == '0) begin
        cur_start_d = tap_i;
      end
      cur_len_d = cur_len_q + TapW'(1);
    end else if (close_run) begin
      if (cur_len_q > best_len_q) begin
        best_start_d = cur_start_q;
        best_len_d   = cur_len_q;
      end
      cur_len_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start_o = best_start_q;
  assign best_len_o   = best_len_q;

endmodule

// File: rtl/adc_link_train.sv
// Link-training controller for one ADC serial bit line.
// Sweeps the IODELAY taps while the ADC sends a fixed pattern, finds the widest
// stable eye, parks the delay at its centre, then bitslips until the word matches.
// Optional feature: define ADC_TRAIN_MONITOR_EN to count post-lock word mismatches
// on errcnt_o (saturating); otherwise errcnt_o is tied to zero.
// Ports:
//   clk_i     clock (receiver DCLK/CLKDIV share this net)
//   rst_i     synchronous active-high reset
//   start_i   one-cycle training request, ignored while busy
//   din_i     6-bit deserialized word
//   bs_o      bitslip pulse
//   dinc_o    IODELAY increment pulse
//   drst_o    IODELAY reset pulse
//   busy_o    training in progress
//   done_o    aligned (sticky until next start/reset)
//   err_o     training failed (sticky until next start/reset)
//   tap_o     current IODELAY tap as tracked here
//   eye_o     best window length found
//   errcnt_o  post-lock mismatch count
module adc_link_train
  import adc_train_pkg::*;
#(
  parameter logic [5:0]  Pattern   = DefPattern,
  parameter int unsigned MaxTap    = 63,
  parameter int unsigned SettleCyc = 16,
  parameter int unsigned CheckCyc  = 32,
  parameter int unsigned MinEye    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [5:0]      din_i,
  output logic            bs_o,
  output logic            dinc_o,
  output logic            drst_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [TapW-1:0] tap_o,
  output logic [TapW-1:0] eye_o,
  output logic [15:0]     errcnt_o
);

  localparam logic [15:0]     SettleLast = 16'(SettleCyc - 1);
  localparam logic [15:0]     CheckLast  = 16'(CheckCyc - 1);
  localparam logic [TapW-1:0] TapMax     = TapW'(MaxTap);
  localparam logic [TapW-1:0] MinEyeT    = TapW'(MinEye);

  logic [3:0]      state_q, state_d;
  logic [3:0]      ret_q, ret_d;      // check state to resume after settling
  logic [15:0]     cnt_q, cnt_d;
  logic [5:0]      first_q, first_d;  // first word of the current check window
  logic            same_q, same_d;    // all words so far equal the first one
  logic [TapW-1:0] tap_q, tap_d;
  logic [TapW-1:0] target_q, target_d;
  logic [2:0]      slips_q, slips_d;
  logic            tog_q, tog_d;      // spaces centring increments two cycles apart
  logic            bs_q, bs_d;
  logic            dinc_q, dinc_d;
  logic            drst_q, drst_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [TapW-1:0] eye_q, eye_d;

  logic            trk_clear, trk_valid, trk_good, trk_close;
  logic [TapW-1:0] best_start, best_len;

  logic            start_accept;
  logic [5:0]      check_word;
  logic            same_next;
  logic            word_is_rot;
  logic [11:0]     pat_dbl;

  assign start_accept = start_i &
                        ((state_q == StIdle) | (state_q == StLocked) | (state_q == StFail));

  // The reference word is the first sample of the window; on the first cycle it is din itself.
  assign check_word = (cnt_q == '0) ? din_i : first_q;
  assign same_next  = ((cnt_q == '0) | same_q) & (din_i == check_word);

  // Rotation matcher: any 6-bit window of the doubled pattern is a rotation.
  assign pat_dbl = {Pattern, Pattern};
  always_comb begin
    word_is_rot = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (pat_dbl[k +: 6] == check_word) begin
        word_is_rot = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    same_d    = same_q;
    tap_d     = tap_q;
    target_d  = target_q;
    slips_d   = slips_q;
    tog_d     = tog_q;
    bs_d      = 1'b0;
    dinc_d    = 1'b0;
    drst_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    eye_d     = eye_q;
    trk_clear = 1'b0;
    trk_valid = 1'b0;
    trk_good  = 1'b0;
    trk_close = 1'b0;

    case (state_q)
      StIdle, StLocked, StFail: begin
        if (start_accept) begin
          done_d    = 1'b0;
          err_d     = 1'b0;
          eye_d     = '0;
          tap_d     = '0;
          slips_d   = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          trk_clear = 1'b1;
          state_d   = StDlyRst;
        end
      end

      StDlyRst: begin
        drst_d  = 1'b1;
        tap_d   = '0;
        cnt_d   = '0;
        ret_d   = StCheck;
        state_d = StSettle;
      end

      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = ret_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StCheck, StSlipCheck: begin
        first_d = check_word;
        same_d  = same_next;
        if (cnt_q == CheckLast) begin
          cnt_d = '0;
          if (state_q == StCheck) begin
            trk_valid = 1'b1;
            trk_good  = same_next & word_is_rot;
            state_d   = StStep;
          end else if (same_next && (check_word == Pattern)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StLocked;
          end else if (slips_q < MaxSlips) begin
            state_d = StSlip;
          end else begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = StFail;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StStep: begin
        if (tap_q < TapMax) begin
          dinc_d  = 1'b1;
          tap_d   = tap_q + TapW'(1);
          cnt_d   = '0;
          ret_d   = StCheck;
          state_d = StSettle;
        end else begin
          // A window still open at the last tap is closed here so it can win.
          trk_close = 1'b1;
          state_d   = StEval;
        end
      end

      StEval: begin
        eye_d = best_len;
        if (best_len < MinEyeT) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StFail;
        end else begin
          target_d = best_start + (best_len >> 1);
          state_d  = StCenterRst;
        end
      end

      StCenterRst: begin
        drst_d  = 1'b1;
        tap_d   = '0;
        tog_d   = 1'b0;
        state_d = StCenterInc;
      end

      StCenterInc: begin
        if (tap_q == target_q) begin
          cnt_d   = '0;
          ret_d   = StSlipCheck;
          state_d = StSettle;
        end else if (!tog_q) begin
          dinc_d = 1'b1;
          tap_d  = tap_q + TapW'(1);
          tog_d  = 1'b1;
        end else begin
          tog_d = 1'b0;
        end
      end

      StSlip: begin
        bs_d    = 1'b1;
        slips_d = slips_q + 3'd1;
        cnt_d   = '0;
        ret_d   = StSlipCheck;
        state_d = StSettle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      ret_q    <= StCheck;
      cnt_q    <= '0;
      first_q  <= '0;
      same_q   <= 1'b0;
      tap_q    <= '0;
      target_q <= '0;
      slips_q  <= '0;
      tog_q    <= 1'b0;
      bs_q     <= 1'b0;
      dinc_q   <= 1'b0;
      drst_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      eye_q    <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      same_q   <= same_d;
      tap_q    <= tap_d;
      target_q <= target_d;
      slips_q  <= slips_d;
      tog_q    <= tog_d;
      bs_q     <= bs_d;
      dinc_q   <= dinc_d;
      drst_q   <= drst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      eye_q    <= eye_d;
    end
  end

  adc_eye_track u_eye_track (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (trk_clear),
    .valid_i      (trk_valid),
    .good_i       (trk_good),
    .tap_i        (tap_q),
    .close_i      (trk_close),
    .best_start_o (best_start),
    .best_len_o   (best_len)
  );

`ifdef ADC_TRAIN_MONITOR_EN
  logic [15:0] errcnt_q, errcnt_d;

  always_comb begin
    errcnt_d = errcnt_q;
    if (start_accept) begin
      errcnt_d = '0;
    end else if ((state_q == StLocked) && (din_i != Pattern) && (errcnt_q != 16'hFFFF)) begin
      errcnt_d = errcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      errcnt_q <= '0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end

  assign errcnt_o = errcnt_q;
`else
  assign errcnt_o = '0;
`endif

  assign bs_o   = bs_q;
  assign dinc_o = dinc_q;
  assign drst_o = drst_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign tap_o  = tap_q;
  assign eye_o  = eye_q;

endmodule

// File: tb/tb_adc_link_train.sv
// Directed bench for adc_link_train with a behavioural receiver model:
// the model tracks the physical tap from DRST/DINC pulses and the bitslip
// phase from BS pulses, and returns a rotation of the pattern on good taps
// and a toggling non-pattern word elsewhere.
module tb_adc_link_train;

  localparam logic [5:0] Pat = 6'b111000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  din;
  logic        bs, dinc, drst, busy, done, err;
  logic [7:0]  tap, eye;
  logic [15:0] errcnt;

  always #5 clk = ~clk;

  adc_link_train dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .din_i    (din),
    .bs_o     (bs),
    .dinc_o   (dinc),
    .drst_o   (drst),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err),
    .tap_o    (tap),
    .eye_o    (eye),
    .errcnt_o (errcnt)
  );

  int checks = 0;
  int passed = 0;

  // Receiver model state
  logic [63:0] good_map = '0;
  int          need = 0;        // slips required to align
  logic        noslip = 1'b0;   // bitslip has no effect (forces slip failure)
  logic        corrupt = 1'b0;
  logic        model_clr = 1'b0;
  logic        tgl = 1'b0;
  int          mtap = 0;
  int          mslips = 0;
  int          n_dinc = 0, n_drst = 0, n_bs = 0, n_multi = 0;
  int          phase;

  function automatic logic [5:0] rotl6(input logic [5:0] p, input int k);
    logic [11:0] t;
    t = {p, p} << k;
    return t[11:6];
  endfunction

  always @(posedge clk) begin
    tgl <= ~tgl;
    if (drst) mtap <= 0;
    else if (dinc) mtap <= mtap + 1;
    if (model_clr) begin
      mslips  <= 0;
      n_dinc  <= 0;
      n_drst  <= 0;
      n_bs    <= 0;
      n_multi <= 0;
    end else begin
      if (bs) mslips <= mslips + 1;
      n_dinc <= n_dinc + int'(dinc);
      n_drst <= n_drst + int'(drst);
      n_bs   <= n_bs + int'(bs);
      if (int'(bs) + int'(dinc) + int'(drst) > 1) n_multi <= n_multi + 1;
    end
  end

  assign phase = noslip ? need : ((need + 6 - (mslips % 6)) % 6);

  always_comb begin
    din = tgl ? 6'h3F : 6'h00;
    if (corrupt) din = 6'b010101;
    else if (mtap >= 0 && mtap < 64 && good_map[mtap]) din = rotl6(Pat, phase);
  end

  task automatic set_windows(input int lo1, input int hi1, input int lo2, input int hi2);
    good_map = '0;
    if (lo1 >= 0) for (int i = lo1; i <= hi1; i++) good_map[i] = 1'b1;
    if (lo2 >= 0) for (int i = lo2; i <= hi2; i++) good_map[i] = 1'b1;
  endtask

  // Pulse START (clearing model counters alongside) and wait for DONE or ERR.
  task automatic run_train(output bit finished);
    model_clr = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
    start     = 1'b0;
    finished  = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if (!busy && (done || err)) begin
        finished = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;  // START during RST must be ignored
    repeat (3) @(negedge clk);
    checks++;
    if ({bs, dinc, drst, busy, done, err, tap, eye, errcnt} !== '0)
      $display("FAIL reset_values: got %h required 0",
               {bs, dinc, drst, busy, done, err, tap, eye, errcnt});
    else passed++;
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL start_during_rst: busy=%b required 0", busy);
    else passed++;
  endtask

  typedef struct {
    int lo1, hi1, lo2, hi2, nd;
    bit nsl;
    bit ok;
    int eye_v, tap_v, bs_v, dinc_v, drst_v;
  } case_t;

  task automatic test_windows();
    case_t tbl[7];
    bit    fin;
    tbl[0] = '{20, 35, -1, -1, 2, 1'b0, 1'b1, 16, 28, 2, 91, 2};
    tbl[1] = '{5, 9, 40, 50, 0, 1'b0, 1'b1, 11, 45, 0, 108, 2};
    tbl[2] = '{5, 10, 30, 35, 1, 1'b0, 1'b1, 6, 8, 1, 71, 2};
    tbl[3] = '{58, 63, -1, -1, 0, 1'b0, 1'b1, 6, 61, 0, 124, 2};
    tbl[4] = '{-1, -1, -1, -1, 0, 1'b0, 1'b0, 0, 63, 0, 63, 1};
    tbl[5] = '{10, 12, -1, -1, 0, 1'b0, 1'b0, 3, 63, 0, 63, 1};
    tbl[6] = '{20, 35, -1, -1, 1, 1'b1, 1'b0, 16, 28, 5, 91, 2};
    for (int c = 0; c < 7; c++) begin
      set_windows(tbl[c].lo1, tbl[c].hi1, tbl[c].lo2, tbl[c].hi2);
      need   = tbl[c].nd;
      noslip = tbl[c].nsl;
      run_train(fin);
      checks++;
      if (fin !== 1'b1) $display("FAIL case%0d_timeout: finished=%b required 1", c, fin);
      else passed++;
      checks++;
      if ({done, err} !== {tbl[c].ok, ~tbl[c].ok})
        $display("FAIL case%0d_done_err: got %b%b required %b%b", c, done, err,
                 tbl[c].ok, ~tbl[c].ok);
      else passed++;
      checks++;
      if (eye !== 8'(tbl[c].eye_v))
        $display("FAIL case%0d_eye: got %0d required %0d", c, eye, tbl[c].eye_v);
      else passed++;
      checks++;
      if (tap !== 8'(tbl[c].tap_v) || mtap != tbl[c].tap_v)
        $display("FAIL case%0d_tap: got %0d (model %0d) required %0d", c, tap, mtap,
                 tbl[c].tap_v);
      else passed++;
      checks++;
      if (n_bs != tbl[c].bs_v || n_dinc != tbl[c].dinc_v || n_drst != tbl[c].drst_v)
        $display("FAIL case%0d_pulses: bs/dinc/drst %0d/%0d/%0d required %0d/%0d/%0d", c,
                 n_bs, n_dinc, n_drst, tbl[c].bs_v, tbl[c].dinc_v, tbl[c].drst_v);
      else passed++;
      checks++;
      if (n_multi != 0) $display("FAIL case%0d_overlap: got %0d required 0", c, n_multi);
      else passed++;
    end
    noslip = 1'b0;
  endtask

  task automatic test_rst_mid();
    bit fin;
    bit hit;
    set_windows(20, 35, -1, -1);
    need      = 0;
    model_clr = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
    start     = 1'b0;
    checks++;
    if ({busy, drst} !== 2'b10) $display("FAIL busy_rise: busy,drst=%b%b required 10", busy, drst);
    else passed++;
    @(negedge clk);
    checks++;
    if (drst !== 1'b1) $display("FAIL drst_follow: drst=%b required 1", drst);
    else passed++;
    hit = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tap == 8'd30) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (hit !== 1'b1) $display("FAIL reach_tap30: reached=%b required 1", hit);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bs, dinc, drst, busy, done, err, tap, eye, errcnt} !== '0)
      $display("FAIL mid_rst_values: got %h required 0",
               {bs, dinc, drst, busy, done, err, tap, eye, errcnt});
    else passed++;
    @(negedge clk);
    checks++;
    if ({drst, busy} !== 2'b00) $display("FAIL mid_rst_idle: drst,busy=%b%b required 00", drst, busy);
    else passed++;
    run_train(fin);
    checks++;
    if ({fin, done, err} !== 3'b110)
      $display("FAIL restart_done: fin,done,err=%b%b%b required 110", fin, done, err);
    else passed++;
    checks++;
    if (tap !== 8'd28 || mtap != 28 || n_drst != 2)
      $display("FAIL restart_tap: tap=%0d model=%0d drst=%0d required 28/28/2", tap, mtap, n_drst);
    else passed++;
  endtask

  task automatic test_monitor();
    bit          fin;
    logic [15:0] exp_cnt;
`ifdef ADC_TRAIN_MONITOR_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    set_windows(20, 35, -1, -1);
    need = 0;
    run_train(fin);
    checks++;
    if ({fin, done, errcnt} !== {2'b11, 16'd0})
      $display("FAIL monitor_lock: fin,done=%b%b errcnt=%0d required 11/0", fin, done, errcnt);
    else passed++;
    corrupt = 1'b1;
    repeat (3) @(negedge clk);
    corrupt = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (errcnt !== exp_cnt) $display("FAIL monitor_errcnt: got %0d required %0d", errcnt, exp_cnt);
    else passed++;
    checks++;
    if ({done, busy, err} !== 3'b100)
      $display("FAIL monitor_done: done,busy,err=%b%b%b required 100", done, busy, err);
    else passed++;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    test_reset();
    test_windows();
    test_rst_mid();
    test_monitor();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
